// File: rtl/ps2_uart_framer_if.sv
// Byte stream from the PS2 frame builder to the UART transmitter.
// Ports: tx_valid/tx_data (producer to consumer), tx_ready (consumer to producer).
interface ps2_uart_framer_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/ps2_uart_framer.sv
// Serialises each PS2 gamepad sample into a 10-byte frame for the UART.
// Ports: i_sys_clk, i_rst_n (sync, active-low), i_ps2_* sample inputs,
//   tx (byte stream master), o_busy, o_frame_done, o_drop_cnt.
module ps2_uart_framer #(
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned FRAME_GAP_CYC = 500
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ps2_valid,
    input  logic                  i_ps2_key_press,
    input  logic                  i_ps2_key_release,
    input  logic [15:0]           i_ps2_key,
    input  logic [7:0]            i_ps2_id,
    input  logic [7:0]            i_ps2_rx,
    input  logic [7:0]            i_ps2_ry,
    input  logic [7:0]            i_ps2_lx,
    input  logic [7:0]            i_ps2_ly,
    ps2_uart_framer_if.master     tx,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic [15:0]           o_drop_cnt
);

    localparam int GW = (FRAME_GAP_CYC > 1) ? $clog2(FRAME_GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        (FRAME_GAP_CYC > 0) ? GW'(FRAME_GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic        press;
        logic        release_f;
        logic [15:0] key;
        logic [7:0]  rx;
        logic [7:0]  ry;
        logic [7:0]  lx;
        logic [7:0]  ly;
    } sample_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    idx;
    logic [GW-1:0] gap_cnt;

    sample_t       live;
    sample_t       pend;
    logic          pend_v;
    sample_t       snap;
    logic [7:0]    snap_chk;

    sample_t       ld;
    logic [7:0]    ld_flags;
    logic [7:0]    ld_chk;
    logic [7:0]    cur_byte;

    logic          hs;
    logic          last_hs;
    logic          gap_end;
    logic          load_live;
    logic          load_pend;
    logic          buf_wr;
    logic          drop;

    assign live = '{
        id:        i_ps2_id,
        press:     i_ps2_key_press,
        release_f: i_ps2_key_release,
        key:       i_ps2_key,
        rx:        i_ps2_rx,
        ry:        i_ps2_ry,
        lx:        i_ps2_lx,
        ly:        i_ps2_ly
    };

    assign hs        = tx.tx_valid && tx.tx_ready;
    assign last_hs   = hs && (idx == 4'd9);
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign load_live = (state == S_IDLE) && i_ps2_valid;
    assign load_pend = (state == S_IDLE) && !i_ps2_valid && pend_v;
    assign buf_wr    = (state != S_IDLE) && i_ps2_valid;
    // A held sample is lost either to a newer sample overwriting it
    // while busy, or to a live strobe winning the idle slot.
    assign drop      = pend_v && i_ps2_valid;

    // Checksum is fixed when the snapshot is taken, so it always
    // matches the bytes that follow regardless of handshake timing.
    assign ld       = load_live ? live : pend;
    assign ld_flags = {6'b0, ld.press, ld.release_f};
    assign ld_chk   = ld.id + ld_flags + ld.key[15:8] + ld.key[7:0]
                    + ld.rx + ld.ry + ld.lx + ld.ly;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (load_live || load_pend) begin
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (last_hs) begin
                    state_nx = (FRAME_GAP_CYC > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        unique case (idx)
            4'd0:    cur_byte = HEADER;
            4'd1:    cur_byte = snap.id;
            4'd2:    cur_byte = {6'b0, snap.press, snap.release_f};
            4'd3:    cur_byte = snap.key[15:8];
            4'd4:    cur_byte = snap.key[7:0];
            4'd5:    cur_byte = snap.rx;
            4'd6:    cur_byte = snap.ry;
            4'd7:    cur_byte = snap.lx;
            4'd8:    cur_byte = snap.ly;
            4'd9:    cur_byte = snap_chk;
            default: cur_byte = 8'h00;
        endcase
    end

    assign tx.tx_valid = (state == S_SEND);
    assign tx.tx_data  = (state == S_SEND) ? cur_byte : 8'h00;
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            idx          <= 4'd0;
            gap_cnt      <= '0;
            pend         <= '0;
            pend_v       <= 1'b0;
            snap         <= '0;
            snap_chk     <= 8'h00;
            o_frame_done <= 1'b0;
            o_drop_cnt   <= 16'h0000;
        end else begin
            o_frame_done <= last_hs;

            if (load_live || load_pend) begin
                snap     <= ld;
                snap_chk <= ld_chk;
                idx      <= 4'd0;
                pend_v   <= 1'b0;
            end else if (last_hs) begin
                idx <= 4'd0;
            end else if (hs) begin
                idx <= idx + 4'd1;
            end

            if (buf_wr) begin
                pend   <= live;
                pend_v <= 1'b1;
            end

            if (state == S_GAP && !gap_end) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if (drop && o_drop_cnt != 16'hFFFF) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

endmodule
